// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the two-port RAM arbiter: request channels in,
// read-response channels out. The master modport is the requester side.
interface ram_arbiter_if #(
    parameter int DATA_LENGTH = 32,
    parameter int MEM_LENGTH  = 32
);
    localparam int AW = $clog2(MEM_LENGTH);

    logic [1:0]             req_valid;
    logic [1:0]             req_we;
    logic [AW-1:0]          req_addr_0;
    logic [AW-1:0]          req_addr_1;
    logic [DATA_LENGTH-1:0] req_wdata_0;
    logic [DATA_LENGTH-1:0] req_wdata_1;
    logic [1:0]             req_ready;
    logic [1:0]             rsp_valid;
    logic [DATA_LENGTH-1:0] rsp_rdata_0;
    logic [DATA_LENGTH-1:0] rsp_rdata_1;
    logic [1:0]             rsp_ready;

    modport master (
        output req_valid, req_we, req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata_0, rsp_rdata_1
    );

    modport slave (
        input  req_valid, req_we, req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata_0, rsp_rdata_1
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters, with a per-port read-response FSM and stall hold register.
module ram_arbiter #(
    parameter int DATA_LENGTH = 32,
    parameter int MEM_LENGTH  = 32,
    localparam int AW = $clog2(MEM_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    ram_arbiter_if.slave           bus,
    output logic                   ram_we,
    output logic [AW-1:0]          ram_address,
    output logic [DATA_LENGTH-1:0] ram_write_data,
    input  logic [DATA_LENGTH-1:0] ram_return_data
);
    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_FLIGHT = 2'd1,
        R_HELD   = 2'd2
    } rsp_state_e;

    rsp_state_e             state_q [2];
    rsp_state_e             state_d [2];
    logic [DATA_LENGTH-1:0] hold_q  [2];
    logic [DATA_LENGTH-1:0] hold_d  [2];
    logic                   last_grant_q;
    logic                   last_grant_d;
    logic [1:0]             elig_s;
    logic [1:0]             grant_s;
    logic [1:0]             rsp_valid_s;
    logic [AW-1:0]          addr_s  [2];
    logic [DATA_LENGTH-1:0] wdata_s [2];
    logic [DATA_LENGTH-1:0] rdata_s [2];

    assign addr_s[0]       = bus.req_addr_0;
    assign addr_s[1]       = bus.req_addr_1;
    assign wdata_s[0]      = bus.req_wdata_0;
    assign wdata_s[1]      = bus.req_wdata_1;
    assign bus.rsp_rdata_0 = rdata_s[0];
    assign bus.rsp_rdata_1 = rdata_s[1];
    assign bus.rsp_valid   = rsp_valid_s;
    assign bus.req_ready   = grant_s;

    // Eligibility: a read waits until that port has no response outstanding; nothing while in reset
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            elig_s[n] = rst & bus.req_valid[n] & (bus.req_we[n] | (state_q[n] == R_IDLE));
        end
    end

    // Grant selection; last_grant_q names the port that won most recently
    always_comb begin
        case (elig_s)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
        if (grant_s[1]) begin
            last_grant_d = 1'b1;
        end else if (grant_s[0]) begin
            last_grant_d = 1'b0;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // RAM drive straight from the granted request, zero when idle
    always_comb begin
        case (grant_s)
            2'b01: begin
                ram_we         = bus.req_we[0];
                ram_address    = addr_s[0];
                ram_write_data = wdata_s[0];
            end
            2'b10: begin
                ram_we         = bus.req_we[1];
                ram_address    = addr_s[1];
                ram_write_data = wdata_s[1];
            end
            default: begin
                ram_we         = 1'b0;
                ram_address    = {AW{1'b0}};
                ram_write_data = {DATA_LENGTH{1'b0}};
            end
        endcase
    end

    // Response FSMs: bypass RAM data in the flight cycle, capture it if the requester stalls
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_d[n]     = state_q[n];
            hold_d[n]      = hold_q[n];
            rdata_s[n]     = {DATA_LENGTH{1'b0}};
            rsp_valid_s[n] = 1'b0;
            case (state_q[n])
                R_IDLE: begin
                    if (grant_s[n] & ~bus.req_we[n]) begin
                        state_d[n] = R_FLIGHT;
                    end else begin
                        state_d[n] = R_IDLE;
                    end
                end
                R_FLIGHT: begin
                    rsp_valid_s[n] = 1'b1;
                    rdata_s[n]     = ram_return_data;
                    if (bus.rsp_ready[n]) begin
                        state_d[n] = R_IDLE;
                    end else begin
                        hold_d[n]  = ram_return_data;
                        state_d[n] = R_HELD;
                    end
                end
                R_HELD: begin
                    rsp_valid_s[n] = 1'b1;
                    rdata_s[n]     = hold_q[n];
                    if (bus.rsp_ready[n]) begin
                        state_d[n] = R_IDLE;
                    end else begin
                        state_d[n] = R_HELD;
                    end
                end
                default: begin
                    state_d[n] = R_IDLE;
                end
            endcase
        end
    end

    // State registers; reset discards any in-flight or held read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= R_IDLE;
                hold_q[n]  <= {DATA_LENGTH{1'b0}};
            end
            last_grant_q <= 1'b1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= state_d[n];
                hold_q[n]  <= hold_d[n];
            end
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares one single-port synchronous RAM between two requesters. Each requester gets a valid/ready request channel for reads and writes, and a valid/ready response channel for read data. The arbiter drives the RAM's `we`/`address`/`write_data` and consumes its registered `return_data`. It sits directly in front of the RAM instance, shares its clock and reset, and contains the grant logic, per-port read-response state machines and response hold registers.

## Interface
- `DATA_LENGTH`, 32, data bus width; must match the RAM.
- `MEM_LENGTH`, 32, RAM depth; address width `AW = $clog2(MEM_LENGTH)`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid[1:0]`  in  2  request present, one bit per port `n`.
- `req_we[1:0]`  in  2  1 = write, 0 = read.
- `req_addr_n`  in  AW  request address, one per port (n = 0, 1).
- `req_wdata_n`  in  DATA_LENGTH  write data, one per port.
- `req_ready[1:0]`  out  2  request accepted this cycle (grant).
- `rsp_valid[1:0]`  out  2  read data available.
- `rsp_rdata_n`  out  DATA_LENGTH  read data, one per port.
- `rsp_ready[1:0]`  in  2  response consumed.
- `ram_we`  out  1  to RAM write enable.
- `ram_address`  out  AW  to RAM address.
- `ram_write_data`  out  DATA_LENGTH  to RAM write data.
- `ram_return_data`  in  DATA_LENGTH  from RAM; updated one edge after a read and held across writes.

## Operation
- **Eligibility.** Port n is eligible when `req_valid[n]` is high and either:
  - the request is a write, or
  - the request is a read and port n's response FSM is in R_IDLE.
- **Grant.** At most one grant per cycle.
  - If only one port is eligible, that port is granted.
  - If both are eligible, the port not equal to `last_grant` is granted.
  - `last_grant` updates on every grant.
- **`req_ready`.** `req_ready[n]` is combinational and asserts only for the granted port. A transfer occurs when `req_valid[n] & req_ready[n]`.
- **RAM drive.** RAM outputs are combinational from the granted request: `ram_we = req_we[g]`, `ram_address = req_addr_g`, `ram_write_data = req_wdata_g`. With no grant, `ram_we = 0` and address/data are 0.
- **Writes.** No response is generated; the write completes at the granting edge.
- **Per-port response FSM.**
  - R_IDLE: on read grant → R_FLIGHT.
  - R_FLIGHT: `rsp_valid = 1`, `rsp_rdata = ram_return_data` (bypass).
    - If `rsp_ready` is high → R_IDLE.
    - Else capture `ram_return_data` into `hold_n` → R_HELD.
  - R_HELD: `rsp_valid = 1`, `rsp_rdata = hold_n`. On `rsp_ready` → R_IDLE.
- **Outstanding reads.** At most one read outstanding per port. A port's read cannot be granted in the cycle its response is being accepted; the earliest next grant is the cycle after.
- **Ordering.** A write followed by a read of the same address, from either port, returns the new data.
- **Same-cycle conflicts.** Simultaneous requests to the same address are serialized by the grant order.

## Timing
- **Reset (asserted, asynchronous).**
  - Both FSMs go to R_IDLE, `last_grant = 1` (port 0 wins first), `hold_n = 0`.
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_rdata = 0`, `ram_we = 0`, `ram_address = 0`, `ram_write_data = 0`.
  - No grants while `rst` is low. The RAM clears on the same reset.
- **Reset mid-operation.** In-flight and held reads are discarded; no `rsp_valid` appears after release.
- **Read latency.** Grant at cycle N, `rsp_valid` at cycle N+1.
- **Throughput.**
  - Writes: 1 per cycle aggregate.
  - Reads: 1 per cycle aggregate when ports alternate; per port, 1 per 2 cycles.
- **Back-to-back across ports.** Port 0 read at N and port 1 write at N+1 are both legal. `ram_return_data` holds across the write, so port 0's response is unaffected.
- **Response stall.** A stalled response holds `rsp_valid` and `rsp_rdata` stable until accepted. The other port is not blocked.

## Test plan
- **Reset values.** Assert `rst` low with both ports valid → all outputs 0 and no `req_ready`. Release → port 0 is granted first.
- **Write/read round trip.** Port 0 writes 0xDEADBEEF @5 at cycle 1, reads @5 at cycle 2 → `rsp_valid[0]` at cycle 3 with 0xDEADBEEF.
- **Round-robin alternation.** Both ports continuously valid with writes to addresses 0..7 → grants alternate 0,1,0,1…; memory holds the last writer's data per address.
- **Response backpressure.** Port 1 reads @3 (= 0x12) with `rsp_ready[1] = 0` for 4 cycles while port 0 writes 0x99 @3 → `rsp_rdata_1` stays 0x12 until accepted. Port 1's next read is not granted until the cycle after acceptance.
- **Interleaved reads.** Port 0 reads @1 at N and port 1 reads @2 at N+1 → `rsp_valid[0]` at N+1 with mem[1], `rsp_valid[1]` at N+2 with mem[2].
- **Reset mid-read.** Pull `rst` low in the R_FLIGHT cycle of a read → `rsp_valid` drops immediately and no response appears after release; a later read of the same address returns 0.
